// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage access controller: serializes the two M-stage lanes' load/store
// requests onto one single-port data-memory req/ack channel, lane 1 before lane 2.
module mem_stage_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          memtoregm,
    input  logic          memwritem,
    input  logic [AW-1:0] aluoutm,
    input  logic [DW-1:0] writedatam,
    input  logic          memtoregm2,
    input  logic          memwritem2,
    input  logic [AW-1:0] aluoutm2,
    input  logic [DW-1:0] writedatam2,
    input  logic          advancem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] readdatam,
    output logic [DW-1:0] readdatam2,
    output logic          stallm,
    output logic          alignerr
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t        state;
    logic          need1;
    logic          need2;
    logic          acc_done;
    logic          issue;
    logic          sel_lane2;
    logic          nxt_aligned;
    logic          nxt_we;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_wdata;

    assign need1 = memtoregm | memwritem;
    assign need2 = memtoregm2 | memwritem2;

    // A new pair is stalled in its very first M cycle, before any state change.
    assign stallm = ((state == IDLE) && (need1 || need2)) || (state == ACC1) || (state == ACC2);

    // A misaligned lane never raises mem_req, so its ACC state finishes at once.
    assign acc_done = !mem_req || mem_ack;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sel_lane2   = 1'b0;
        issue       = 1'b0;
        nxt_aligned = 1'b0;
        nxt_we      = 1'b0;
        nxt_addr    = '0;
        nxt_wdata   = '0;

        case (state)
            IDLE:    begin
                issue     = need1 || need2;
                sel_lane2 = !need1;
            end
            ACC1:    begin
                issue     = acc_done && need2;
                sel_lane2 = 1'b1;
            end
            default: begin
                issue     = 1'b0;
                sel_lane2 = 1'b0;
            end
        endcase

        // Store wins when a lane asserts both load and store.
        if (sel_lane2) begin
            nxt_aligned = (aluoutm2[1:0] == 2'b00);
            nxt_we      = memwritem2;
            nxt_addr    = {aluoutm2[AW-1:2], 2'b00};
            nxt_wdata   = writedatam2;
        end else begin
            nxt_aligned = (aluoutm[1:0] == 2'b00);
            nxt_we      = memwritem;
            nxt_addr    = {aluoutm[AW-1:2], 2'b00};
            nxt_wdata   = writedatam;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the read-data holders are reset too; they are visible outputs, not RAM.
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            readdatam  <= '0;
            readdatam2 <= '0;
            alignerr   <= 1'b0;
        end else begin
            // NOTE: registered state is updated with non-blocking assignments only.
            alignerr <= 1'b0;

            // Request fields are loaded on entry to an ACC state and held until ack.
            if (issue) begin
                mem_req   <= nxt_aligned;
                mem_we    <= nxt_we && nxt_aligned;
                mem_addr  <= nxt_addr;
                mem_wdata <= nxt_wdata;
                alignerr  <= !nxt_aligned;
            end

            case (state)
                IDLE: begin
                    if (need1) begin
                        state <= ACC1;
                    end else if (need2) begin
                        state <= ACC2;
                    end
                end
                ACC1: begin
                    if (acc_done) begin
                        if (mem_req && !mem_we) begin
                            readdatam <= mem_rdata;
                        end
                        if (need2) begin
                            state <= ACC2;
                        end else begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                ACC2: begin
                    if (acc_done) begin
                        if (mem_req && !mem_we) begin
                            readdatam2 <= mem_rdata;
                        end
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                DONE: begin
                    // The completed pair is never re-issued; wait for the pipeline to move.
                    if (advancem) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Self-checking bench for mem_stage_access_ctrl: table-driven lane pairs against a
// wait-state memory model, with a transaction scoreboard and hand-written corner cases.
module tb_mem_stage_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          memtoregm = 1'b0, memwritem = 1'b0;
    logic [AW-1:0] aluoutm = '0;
    logic [DW-1:0] writedatam = '0;
    logic          memtoregm2 = 1'b0, memwritem2 = 1'b0;
    logic [AW-1:0] aluoutm2 = '0;
    logic [DW-1:0] writedatam2 = '0;
    logic          advancem = 1'b0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] readdatam, readdatam2;
    logic          stallm, alignerr;

    mem_stage_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .memtoregm(memtoregm), .memwritem(memwritem),
        .aluoutm(aluoutm), .writedatam(writedatam),
        .memtoregm2(memtoregm2), .memwritem2(memwritem2),
        .aluoutm2(aluoutm2), .writedatam2(writedatam2),
        .advancem(advancem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .readdatam(readdatam), .readdatam2(readdatam2),
        .stallm(stallm), .alignerr(alignerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        ld1, st1;
        logic [31:0] a1, wd1;
        logic        ld2, st2;
        logic [31:0] a2, wd2;
        int          wt;
        int          exp_stall;
        int          exp_align;
        logic [31:0] exp_rd1, exp_rd2;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    txn_t exp_q[$];
    txn_t obs[$];
    int   obs_idx = 0;
    int   mem_wait = 0;
    bit   force_ack = 1'b0;
    int   wcnt = 0;
    logic [31:0] mem_model [logic [31:0]];
    vec_t vecs [9];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    // Memory responder: acks after mem_wait low cycles; force_ack models a stray held ack.
    always @(negedge clk) begin
        if (mem_ack) wcnt = 0;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (mem_req) begin
            if (wcnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_read(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    // Records every completed handshake and applies writes to the memory model.
    initial begin
        mem_model[32'h100] = 32'hDEAD_BEEF;
        mem_model[32'h040] = 32'hCAFE_F00D;
        forever begin
            @(posedge clk);
            if (rst_n && mem_req && mem_ack) begin
                obs.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                if (mem_we) mem_model[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_lane(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd);
        if ((ld || st) && (a[1:0] == 2'b00))
            exp_q.push_back('{we: st, addr: a, wdata: (st ? wd : 32'h0)});
    endtask

    task automatic drive(input vec_t v);
        memtoregm  = v.ld1; memwritem  = v.st1; aluoutm  = v.a1; writedatam  = v.wd1;
        memtoregm2 = v.ld2; memwritem2 = v.st2; aluoutm2 = v.a2; writedatam2 = v.wd2;
        push_lane(v.ld1, v.st1, v.a1, v.wd1);
        push_lane(v.ld2, v.st2, v.a2, v.wd2);
    endtask

    // Counts stalled cycles (sampled mid low phase) until stallm drops, bounded.
    task automatic wait_done(input string tag, output int stall_n, output int al_n);
        bit done;
        done = 1'b0; stall_n = 0; al_n = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (alignerr === 1'b1) al_n++;
            if (stallm === 1'b0) begin
                done = 1'b1;
                break;
            end
            stall_n++;
            @(negedge clk);
        end
        if (!done) check({tag, "_timeout"}, 32'(stallm), 32'h0);
    endtask

    task automatic check_txns(input string tag);
        txn_t e, o;
        check({tag, "_txn_count"}, 32'(obs.size() - obs_idx), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_idx < obs.size()) begin
            e = exp_q.pop_front();
            o = obs[obs_idx];
            obs_idx++;
            check({tag, "_txn_we"}, 32'(o.we), 32'(e.we));
            check({tag, "_txn_addr"}, o.addr, e.addr);
            if (e.we) check({tag, "_txn_wdata"}, o.wdata, e.wdata);
        end
        exp_q.delete();
        obs_idx = obs.size();
    endtask

    task automatic advance();
        advancem = 1'b1;
        @(negedge clk);
        advancem = 1'b0;
        memtoregm = 1'b0; memwritem = 1'b0; memtoregm2 = 1'b0; memwritem2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_n, al_n;
        string tag;

        //          ld1   st1   a1           wd1           ld2   st2   a2           wd2      wt st al rd1           rd2
        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,       2, 4, 0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h200, 32'h0,       0, 3, 0, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h040, 32'h0,       0, 2, 0, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b0, 32'h102, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,       0, 2, 1, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,   32'h0,       1, 3, 0, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 1'b1, 32'h207, 32'h55,      1, 4, 1, 32'hFFFFFEFB, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,       0, 0, 0, 32'hFFFFFEFB, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'h101, 32'h0,        1'b1, 1'b0, 32'h043, 32'h0,       0, 3, 2, 32'hFFFFFEFB, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b1, 32'h044, 32'h0BADF00D, 1'b1, 1'b0, 32'h044, 32'h0,       1, 5, 0, 32'hFFFFFEFB, 32'h0BADF00D};

        // Reset state: asynchronous, visible before the first clock edge.
        #2;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_readdatam", readdatam, 32'h0);
        check("rst_readdatam2", readdatam2, 32'h0);
        check("rst_alignerr", 32'(alignerr), 32'h0);
        check("rst_stallm", 32'(stallm), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            tag = $sformatf("v%0d", i);
            mem_wait = vecs[i].wt;
            @(negedge clk);
            drive(vecs[i]);
            wait_done(tag, stall_n, al_n);
            check({tag, "_stall_cycles"}, 32'(stall_n), 32'(vecs[i].exp_stall));
            check({tag, "_alignerr_pulses"}, 32'(al_n), 32'(vecs[i].exp_align));
            check({tag, "_readdatam"}, readdatam, vecs[i].exp_rd1);
            check({tag, "_readdatam2"}, readdatam2, vecs[i].exp_rd2);
            check({tag, "_req_idle"}, 32'(mem_req), 32'h0);
            check_txns(tag);
            advance();
        end

        // DONE held without advancem while the memory drives a stray ack.
        mem_wait = 0;
        @(negedge clk);
        memtoregm = 1'b1; aluoutm = 32'h300;
        push_lane(1'b1, 1'b0, 32'h300, 32'h0);
        wait_done("hold", stall_n, al_n);
        check("hold_stall_cycles", 32'(stall_n), 32'h2);
        force_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_stallm_c%0d", c), 32'(stallm), 32'h0);
            check($sformatf("hold_req_c%0d", c), 32'(mem_req), 32'h0);
        end
        force_ack = 1'b0;
        check("hold_readdatam", readdatam, 32'hA5A5A5A5);
        check_txns("hold");
        advance();

        // Reset asserted mid ACC1 while the ack is still pending.
        mem_wait = 10;
        @(negedge clk);
        memtoregm = 1'b1; aluoutm = 32'h104;
        @(negedge clk);
        #1;
        check("midrst_pre_req", 32'(mem_req), 32'h1);
        check("midrst_pre_addr", mem_addr, 32'h104);
        #1;
        rst_n = 1'b0;
        force_ack = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_readdatam", readdatam, 32'h0);
        check("midrst_readdatam2", readdatam2, 32'h0);
        memtoregm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("postrst_stallm_c%0d", c), 32'(stallm), 32'h0);
            check($sformatf("postrst_req_c%0d", c), 32'(mem_req), 32'h0);
        end
        force_ack = 1'b0;
        check("postrst_readdatam", readdatam, 32'h0);
        check_txns("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_ctrl.md
# mem_stage_access_ctrl

Memory-stage access controller for the dual-issue pipeline. It takes load/store requests from both M-stage lanes, serializes them onto a single-port data-memory req/ack interface (lane 1 first, lane 2 second), and raises `stallm` toward the hazard controller until every access for the current M-stage pair has completed. It sources `stallm` and consumes the pipeline-advance indication that the hazard controller's stall outputs produce.

## Interface
- `AW`, 32, address width (byte address)
- `DW`, 32, data width (word)

- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `memtoregm`, `memwritem`  in  1 each  lane 1 load / store request in M
- `aluoutm`  in  AW  lane 1 byte address
- `writedatam`  in  DW  lane 1 store data
- `memtoregm2`, `memwritem2`  in  1 each  lane 2 load / store request in M
- `aluoutm2`  in  AW  lane 2 byte address
- `writedatam2`  in  DW  lane 2 store data
- `advancem`  in  1  M-stage pipeline register loads a new pair at the next rising edge
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  AW  word-aligned byte address
- `mem_wdata`  out  DW  write data
- `mem_rdata`  in  DW  read data, valid when `mem_ack`=1
- `mem_ack`  in  1  access complete
- `readdatam`, `readdatam2`  out  DW each  captured load data, lanes 1 / 2
- `stallm`  out  1  stall request to hazard controller
- `alignerr`  out  1  one-cycle pulse: misaligned access dropped

## Operation
- Lane needs access: `need1 = memtoregm | memwritem`, `need2 = memtoregm2 | memwritem2`. If both load and store are set on one lane, store wins (`mem_we`=1), no read data captured.
- FSM states: IDLE, ACC1, ACC2, DONE.
- IDLE: if `need1` → ACC1; else if `need2` → ACC2; else stay.
- ACC1: `mem_req`=1, `mem_we`/`mem_addr`/`mem_wdata` from lane 1. On `mem_ack`: capture `mem_rdata` into `readdatam` if load; → ACC2 if `need2`, else DONE.
- ACC2: same using lane 2 / `readdatam2`; on `mem_ack` → DONE.
- DONE: `stallm`=0; on `advancem` → IDLE; else stay (the same pair is never re-issued).
- `stallm = (IDLE & (need1|need2)) | ACC1 | ACC2`; combinational so a new pair is stalled in its first M cycle.
- Misaligned (`addr[1:0]`≠0) lane: no `mem_req` issued. Entering that lane's ACC state completes it in one cycle without request; read data register unchanged; `alignerr`=1 that cycle.
- `mem_ack` in IDLE or DONE ignored. Lane inputs are held stable by the pipeline while `stallm`=1.
- `mem_addr` = lane address with bits [1:0] forced to 0 (aligned case: unchanged).

## Timing
- Reset (async, immediate): state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `readdatam`=`readdatam2`=0, `alignerr`=0; `stallm` follows IDLE equation. Reset mid-access abandons it; a held `mem_ack` after reset release is ignored in IDLE.
- `mem_req` and data/address are functions of registered state only; stable until ack.
- Request completes at the rising edge where `mem_req`=1 and `mem_ack`=1; `mem_req` low (or switched to lane 2) the next cycle.
- Single access, zero-wait ack: `stallm` high 2 cycles (IDLE, ACC1), low in DONE. Two accesses, zero-wait: 3 cycles. Each wait cycle on `mem_ack` adds one.
- `readdatamN` valid from the cycle after its ack and held until next load on that lane or reset.
- DONE with `advancem`=0 (other stall active): `stallm` stays 0, no new request.

## Test plan
- Lane 1 load `aluoutm`=0x100, ack after 2 wait cycles with `mem_rdata`=0xDEADBEEF → one read at 0x100, `stallm` high 4 cycles, `readdatam`=0xDEADBEEF.
- Lane 1 store 0x200/0x12345678 plus lane 2 load 0x200, zero-wait memory returning stored data → write then read in order, `readdatam2`=0x12345678, `stallm` high 3 cycles.
- Lane 2 only load 0x40 → single read from lane 2, ACC1 skipped, `readdatam` unchanged.
- Lane 1 load at 0x102 → no `mem_req`, `alignerr` one pulse, `stallm` high 2 cycles.
- DONE held with `advancem`=0 for 5 cycles, stray `mem_ack`=1 → no re-issue, `stallm`=0 throughout.
- `rst_n` asserted mid ACC1 with ack pending → `mem_req` drops same cycle, outputs 0; after release with no requests, `stallm`=0.
